xor_tree_pipe: RTL and testbench
================================

// Module: xor_tree_pipe
// PURPOSE
//   Parametrised, pipelined XOR-reduction of N_CH register channels. Successor to the fixed
//   five-register hierarchical XOR collector: channel count, width and mode are generalised,
//   with per-beat channel masking, valid/ready flow control and an optional accumulate mode.
//   Sits between per-channel capture registers and a single observation/compare register.
// PARAMETERS
//   N_CH   5  number of input channels, >= 2
//   WIDTH  1  bits per channel, >= 1
//   MODE   0  0 = per-beat XOR; 1 = running XOR accumulated across accepted beats
// PORTS
//   clk        in   1            single clock, rising edge
//   rst_n      in   1            asynchronous reset, active low
//   in_valid   in   1            beat offered on in_data/in_mask
//   in_ready   out  1            beat accepted when in_valid && in_ready
//   in_data    in   N_CH*WIDTH   channel i at [i*WIDTH +: WIDTH]
//   in_mask    in   N_CH         1 = channel contributes, 0 = channel forced to zero
//   acc_clr    in   1            MODE=1 only: clear accumulator; ignored when MODE=0
//   out_valid  out  1            result available
//   out_ready  in   1            result consumed when out_valid && out_ready
//   out_data   out  WIDTH        XOR result
// BEHAVIOUR
//   - Reset (rst_n low, async): every stage valid bit, every stage data register and acc go to 0.
//     Outputs: out_valid=0, out_data=0. in_ready=1 on the first cycle after release.
//   - Stage 0 captures in_data AND-ed with the per-channel mask.
//   - LEVELS = $clog2(N_CH) tree levels follow stage 0, each registered. Each level XORs adjacent
//     pairs. An odd unpaired node is passed through unchanged, registered.
//   - Latency: 1 + LEVELS cycles from the acceptance edge to out_valid=1.
//     For N_CH=5 this is 4 cycles; for N_CH=2 it is 2.
//   - Flow control: global advance en = !out_valid || out_ready; in_ready = en, combinational.
//     When en=0 every stage holds, including its valid bits. When en=1 every stage shifts by one;
//     bubbles shift like beats. Throughput is 1 beat/cycle while out_ready=1.
//   - No beat is dropped or duplicated; order is preserved.
//   - MODE=0: out_data = last-stage register.
//   - MODE=1: out_data = last-stage register ^ acc, driven from registers only.
//     On an output handshake, acc <= acc_clr ? 0 : out_data.
//     acc_clr without a handshake: acc <= 0.
//     acc_clr coincident with a handshake: the current beat is still presented including the
//     old acc, and acc ends at 0 (clear wins).
//   - out_data holds its value while out_valid=1 && out_ready=0.
//   - When out_valid=0, out_data is don't-care; the bench must not check it.
//   - Widths: all arithmetic is bitwise XOR at WIDTH bits; no carries, no extension.
//   - Reset mid-operation: all in-flight beats are discarded and acc is cleared.
//     No pre-reset beat ever appears after release.
// TESTING  (N_CH=5, WIDTH=8 unless stated)
//   1. Hold rst_n=0 for 3 cycles -> out_valid=0, out_data=8'h00, in_ready=1 after release.
//   2. One beat: channels 0..4 = 01,02,04,08,10, mask 5'b11111 -> out_data=8'h1F,
//      out_valid high 4 cycles after the accept edge, for exactly 1 cycle with out_ready=1.
//   3. Same data, mask 5'b00101 -> out_data=8'h05. Mask 5'b00000 -> out_data=8'h00.
//   4. 6 back-to-back beats, out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall,
//      all 6 results appear in order, none lost or repeated.
//   5. MODE=1: beats 1F then 0F -> outputs 8'h1F, 8'h10.
//      Then acc_clr=1 for 1 idle cycle, beat 03 -> 8'h03.
//      acc_clr on the handshake of beat 8'h03 -> next beat 8'h07 outputs 8'h07.
//   6. Assert rst_n=0 with 3 beats in flight -> out_valid=0 immediately.
//      After release, no stale results; a new beat 8'hAA on ch0 only (mask 5'b00001) -> 8'hAA.
//      Also run N_CH=2 and N_CH=8 (WIDTH=1) random compare against a reference model.

Source files
------------

// File: rtl/xor_tree_pipe.sv
// Pipelined, mask-gated XOR reduction of N_CH channels with valid/ready flow control.
// MODE=1 folds each result into a running accumulator that acc_clr can clear.
module xor_tree_pipe #(
    parameter int N_CH  = 5,
    parameter int WIDTH = 1,
    parameter int MODE  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_mask,
    input  logic                  acc_clr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data
);
    localparam int LEVELS = $clog2(N_CH);

    // Handshake: a beat moves on a clock edge only when valid && ready are both high.
    // One global enable: the whole pipe shifts together, bubbles included.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int CNT = (N_CH + (1 << l) - 1) >> l;
        logic [WIDTH-1:0] nd  [CNT];
        logic [WIDTH-1:0] nxt [CNT];
        logic             vld;
        logic             vld_nxt;

        if (l == 0) begin : g_cap
            assign vld_nxt = in_valid;
            for (genvar j = 0; j < CNT; j++) begin : g_node
                assign nxt[j] = in_data[j*WIDTH +: WIDTH] & {WIDTH{in_mask[j]}};
            end
        end else begin : g_tree
            localparam int PCNT = (N_CH + (1 << (l - 1)) - 1) >> (l - 1);
            assign vld_nxt = g_lvl[l-1].vld;
            for (genvar j = 0; j < CNT; j++) begin : g_node
                if (2 * j + 1 < PCNT) begin : g_pair
                    assign nxt[j] = g_lvl[l-1].nd[2*j] ^ g_lvl[l-1].nd[2*j+1];
                end else begin : g_odd
                    assign nxt[j] = g_lvl[l-1].nd[2*j];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld <= 1'b0;
                for (int j = 0; j < CNT; j++) nd[j] <= '0;
            end else if (en) begin
                vld <= vld_nxt;
                nd  <= nxt;
            end
        end
    end

    logic [WIDTH-1:0] last;
    assign last      = g_lvl[LEVELS].nd[0];
    assign out_valid = g_lvl[LEVELS].vld;

    if (MODE == 1) begin : g_acc
        logic [WIDTH-1:0] acc;
        // Clear wins over the handshake update; the beat on the handshake still shows the old acc.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                      acc <= '0;
            else if (acc_clr)                acc <= '0;
            else if (out_valid && out_ready) acc <= out_data;
        end
        assign out_data = last ^ acc;
    end else begin : g_plain
        assign out_data = last;
    end
endmodule

// File: tb/tb_xor_tree_pipe.sv
// Scoreboard bench for xor_tree_pipe: two N_CH=5/WIDTH=8 instances (MODE 0 and 1)
// plus N_CH=2 and N_CH=8 WIDTH=1 instances driven with random beats.
module tb_xor_tree_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int n_cmp = 0;
    int n_err = 0;

    logic        p_in_valid, p_in_ready, p_acc_clr, p_out_valid, p_out_ready;
    logic [39:0] p_in_data;
    logic [4:0]  p_in_mask;
    logic [7:0]  p_out_data;
    logic        a_in_valid, a_in_ready, a_acc_clr, a_out_valid, a_out_ready;
    logic [39:0] a_in_data;
    logic [4:0]  a_in_mask;
    logic [7:0]  a_out_data;
    logic        s_in_valid, s_in_ready, s_acc_clr, s_out_valid, s_out_ready;
    logic [1:0]  s_in_data, s_in_mask;
    logic        s_out_data;
    logic        w_in_valid, w_in_ready, w_acc_clr, w_out_valid, w_out_ready;
    logic [7:0]  w_in_data, w_in_mask;
    logic        w_out_data;

    logic [7:0] p_q[$];
    logic [7:0] a_q[$];
    logic [0:0] s_q[$];
    logic [0:0] w_q[$];

    xor_tree_pipe #(.N_CH(5), .WIDTH(8), .MODE(0)) u_p (
        .clk(clk), .rst_n(rst_n), .in_valid(p_in_valid), .in_ready(p_in_ready),
        .in_data(p_in_data), .in_mask(p_in_mask), .acc_clr(p_acc_clr),
        .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data));
    xor_tree_pipe #(.N_CH(5), .WIDTH(8), .MODE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_mask(a_in_mask), .acc_clr(a_acc_clr),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data));
    xor_tree_pipe #(.N_CH(2), .WIDTH(1), .MODE(0)) u_s (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .in_mask(s_in_mask), .acc_clr(s_acc_clr),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data));
    xor_tree_pipe #(.N_CH(8), .WIDTH(1), .MODE(0)) u_w (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_data(w_in_data), .in_mask(w_in_mask), .acc_clr(w_acc_clr),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Monitors: pop the scoreboard on every output handshake
    always @(negedge clk) begin
        if (rst_n && p_out_valid && p_out_ready) begin
            if (p_q.size() == 0) check("p_unexpected_beat", 1, 0);
            else check("p_data", p_out_data, p_q.pop_front());
        end
        if (rst_n && a_out_valid && a_out_ready) begin
            if (a_q.size() == 0) check("a_unexpected_beat", 1, 0);
            else check("a_data", a_out_data, a_q.pop_front());
        end
        if (rst_n && s_out_valid && s_out_ready) begin
            if (s_q.size() == 0) check("s_unexpected_beat", 1, 0);
            else check("s_data", s_out_data, s_q.pop_front());
        end
        if (rst_n && w_out_valid && w_out_ready) begin
            if (w_q.size() == 0) check("w_unexpected_beat", 1, 0);
            else check("w_data", w_out_data, w_q.pop_front());
        end
    end

    task automatic send_p(input logic [39:0] d, input logic [4:0] m, input logic [7:0] exp);
        logic acc;
        int   budget;
        acc = 1'b0;
        budget = 0;
        p_in_valid = 1'b1; p_in_data = d; p_in_mask = m;
        while (!acc && budget < 50) begin
            @(negedge clk);
            acc = p_in_ready;
            budget++;
            @(posedge clk); #1;
        end
        if (!acc) check("p_accept_timeout", 0, 1);
        else p_q.push_back(exp);
        p_in_valid = 1'b0;
    endtask

    task automatic send_a(input logic [39:0] d, input logic [4:0] m, input logic [7:0] exp);
        logic acc;
        int   budget;
        acc = 1'b0;
        budget = 0;
        a_in_valid = 1'b1; a_in_data = d; a_in_mask = m;
        while (!acc && budget < 50) begin
            @(negedge clk);
            acc = a_in_ready;
            budget++;
            @(posedge clk); #1;
        end
        if (!acc) check("a_accept_timeout", 0, 1);
        else a_q.push_back(exp);
        a_in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int budget;
        budget = 0;
        while ((p_q.size() != 0 || a_q.size() != 0 || s_q.size() != 0 || w_q.size() != 0 ||
                p_out_valid || a_out_valid || s_out_valid || w_out_valid) && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 200) check(name, 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic run_rand_s(input int n);
        int sent;
        int guard;
        sent = 0;
        guard = 0;
        while (sent < n && guard < 2000) begin
            @(posedge clk); #1;
            s_in_valid  = 1'($urandom_range(0, 1));
            s_in_data   = 2'($urandom_range(0, 3));
            s_in_mask   = 2'($urandom_range(0, 3));
            s_out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (s_in_valid && s_in_ready) begin
                s_q.push_back(^(s_in_data & s_in_mask));
                sent++;
            end
            guard++;
        end
        @(posedge clk); #1;
        s_in_valid = 1'b0; s_out_ready = 1'b1;
    endtask

    task automatic run_rand_w(input int n);
        int sent;
        int guard;
        sent = 0;
        guard = 0;
        while (sent < n && guard < 2000) begin
            @(posedge clk); #1;
            w_in_valid  = 1'($urandom_range(0, 1));
            w_in_data   = 8'($urandom_range(0, 255));
            w_in_mask   = 8'($urandom_range(0, 255));
            w_out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (w_in_valid && w_in_ready) begin
                w_q.push_back(^(w_in_data & w_in_mask));
                sent++;
            end
            guard++;
        end
        @(posedge clk); #1;
        w_in_valid = 1'b0; w_out_ready = 1'b1;
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0;
        p_in_valid = 0; p_in_data = '0; p_in_mask = '0; p_acc_clr = 0; p_out_ready = 1;
        a_in_valid = 0; a_in_data = '0; a_in_mask = '0; a_acc_clr = 0; a_out_ready = 1;
        s_in_valid = 0; s_in_data = '0; s_in_mask = '0; s_acc_clr = 0; s_out_ready = 1;
        w_in_valid = 0; w_in_data = '0; w_in_mask = '0; w_acc_clr = 0; w_out_ready = 1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_p_out_valid", p_out_valid, 0);
        check("rst_p_out_data", p_out_data, 8'h00);
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_a_out_data", a_out_data, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_p_in_ready", p_in_ready, 1);
        check("rst_a_in_ready", a_in_ready, 1);
        @(posedge clk); #1;

        // Single beat, latency and single-cycle valid
        send_p(40'h10_08_04_02_01, 5'b11111, 8'h1F);
        cnt = 1;
        while (!p_out_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("p_latency", cnt, 4);
        @(posedge clk); #1;
        check("p_single_cycle_valid", p_out_valid, 0);

        // Masking
        send_p(40'h10_08_04_02_01, 5'b00101, 8'h05);
        send_p(40'h10_08_04_02_01, 5'b00000, 8'h00);
        wait_idle("idle_timeout_mask");

        // Back-to-back with a 3-cycle output stall
        fork
            begin
                send_p(40'h01_F0_0F_5A_A5, 5'b11111, 8'h01);
                send_p(40'h01_F0_0F_5A_A5, 5'b00011, 8'hFF);
                send_p(40'h9A_78_56_34_12, 5'b11111, 8'h92);
                send_p(40'h9A_78_56_34_12, 5'b10000, 8'h9A);
                send_p(40'h9A_78_56_34_12, 5'b01010, 8'h4C);
                send_p(40'hFF_FF_FF_FF_FF, 5'b10101, 8'hFF);
            end
            begin
                cnt = 0;
                while (!p_out_valid && cnt < 50) begin
                    @(negedge clk);
                    cnt++;
                end
                @(posedge clk); #1;
                p_out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("p_stall_in_ready", p_in_ready, 0);
                    @(posedge clk); #1;
                end
                p_out_ready = 1'b1;
            end
        join
        wait_idle("idle_timeout_stall");

        // Accumulate mode
        send_a(40'h10_08_04_02_01, 5'b11111, 8'h1F);
        send_a(40'h00_08_04_02_01, 5'b11111, 8'h10);
        wait_idle("idle_timeout_acc1");
        a_acc_clr = 1'b1;
        @(posedge clk); #1;
        a_acc_clr = 1'b0;
        send_a(40'h00_00_00_00_03, 5'b00001, 8'h03);
        cnt = 0;
        @(negedge clk);
        while (!a_out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        a_acc_clr = 1'b1;
        @(posedge clk); #1;
        a_acc_clr = 1'b0;
        send_a(40'h00_00_00_00_07, 5'b00001, 8'h07);
        wait_idle("idle_timeout_acc2");

        // Reset with beats in flight
        send_p(40'h00_00_00_00_11, 5'b00001, 8'h11);
        send_p(40'h00_00_00_00_22, 5'b00001, 8'h22);
        send_p(40'h00_00_00_00_33, 5'b00001, 8'h33);
        rst_n = 1'b0;
        p_q.delete();
        #1;
        check("midrst_out_valid", p_out_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("postrst_no_stale", p_out_valid, 0);
        send_p(40'hFF_FF_FF_FF_AA, 5'b00001, 8'hAA);
        wait_idle("idle_timeout_rst");

        // Other channel counts against a parity model
        fork
            run_rand_s(40);
            run_rand_w(40);
        join
        wait_idle("idle_timeout_rand");

        check("p_leftover", p_q.size(), 0);
        check("a_leftover", a_q.size(), 0);
        check("s_leftover", s_q.size(), 0);
        check("w_leftover", w_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
